// File: rtl/m_cache_assoc_pkg.sv
// Shared types and helpers for the fully-associative cache.
//   state_e : cache controller FSM states
//   clog2   : constant ceil(log2) used to size line indices and ages
package m_cache_assoc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_EVICT  = 3'd2,
    ST_FILL   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/m_cache_assoc_lru.sv
// True-LRU age tracker for the fully-associative cache.
// Ports:
//   clock, reset_n : clock / async active-low reset (ages reset to age[i]=i)
//   valid          : per-line valid bits, used for invalid-first victim choice
//   touch          : strobe, marks touch_line as most recently used
//   touch_line     : line index being touched
//   victim         : lowest-index invalid line, else the line with the max age
//   ages           : current age of each line (always a permutation)
module m_cache_lru
  import m_cache_assoc_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [LINES-1:0]                 valid,
  input  logic                             touch,
  input  logic [clog2(LINES)-1:0]          touch_line,
  output logic [clog2(LINES)-1:0]          victim,
  output logic [LINES-1:0][clog2(LINES)-1:0] ages
);

  localparam int AW = clog2(LINES);

  logic [LINES-1:0][AW-1:0] age_nxt;

  // Per-line next age: touched line becomes youngest, every line younger than
  // it ages by one. Lines older than the touched one keep their age, so the
  // set stays a permutation and nothing can pass LINES-1.
  for (genvar i = 0; i < LINES; i++) begin : g_age
    assign age_nxt[i] = (touch_line == AW'(i))             ? '0 :
                        (ages[i] < ages[touch_line])       ? ages[i] + 1'b1 :
                                                             ages[i];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) ages[i] <= AW'(i);
    end else if (touch) begin
      ages <= age_nxt;
    end
  end

  always_comb begin
    logic found;
    found  = 1'b0;
    victim = '0;
    for (int i = 0; i < LINES; i++) begin
      if (!found && !valid[i]) begin
        victim = AW'(i);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int i = 0; i < LINES; i++)
        if (ages[i] == AW'(LINES - 1)) victim = AW'(i);
    end
  end

endmodule

// File: rtl/m_cache_assoc.sv
// Fully-associative write-back cache, one word per line, true-LRU replacement,
// write-allocate without fill on write miss.
// Ports:
//   clock, reset_n            : clock / async active-low reset (clears all state)
//   req_valid/ready/wren/addr/data : request port, accepted on valid & ready
//   resp_valid/data/hit       : one-cycle completion pulse with read data / hit flag
//   mem_req/wren/addr/wdata   : memory request, held until mem_ack
//   mem_ack/rdata             : memory completion pulse and fill data
module m_cache_assoc
  import m_cache_assoc_pkg::*;
#(
  parameter int LINES  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wren,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  output logic              mem_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LW = clog2(LINES);

  state_e state, nstate;

  logic [LINES-1:0][ADDR_W-1:0] tag;
  logic [LINES-1:0][DATA_W-1:0] data;
  logic [LINES-1:0]             valid;
  logic [LINES-1:0]             dirty;

  logic              r_wren;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [LW-1:0]     r_line;

  logic [LINES-1:0] line_match;
  logic             hit;
  logic [LW-1:0]    hit_line;
  logic [LW-1:0]    victim;
  logic             victim_dirty;
  logic [LINES-1:0][LW-1:0] ages;

  // Tag compare per line; at most one line can match.
  for (genvar i = 0; i < LINES; i++) begin : g_match
    assign line_match[i] = valid[i] && (tag[i] == r_addr);
  end

  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int i = 0; i < LINES; i++) begin
      if (line_match[i]) begin
        hit      = 1'b1;
        hit_line = LW'(i);
      end
    end
  end

  assign victim_dirty = valid[victim] && dirty[victim];

  m_cache_lru #(.LINES(LINES)) u_lru (
    .clock      (clock),
    .reset_n    (reset_n),
    .valid      (valid),
    .touch      (state == ST_RESP),
    .touch_line (r_line),
    .victim     (victim),
    .ages       (ages)
  );

  // Outputs decoded from state so a reset drops them immediately.
  assign req_ready  = reset_n && (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign mem_req    = (state == ST_EVICT) || (state == ST_FILL);
  assign mem_wren   = (state == ST_EVICT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:   if (req_valid) nstate = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit)               nstate = ST_RESP;
        else if (victim_dirty) nstate = ST_EVICT;
        else if (r_wren)       nstate = ST_RESP;
        else                   nstate = ST_FILL;
      end
      ST_EVICT:  if (mem_ack) nstate = r_wren ? ST_RESP : ST_FILL;
      ST_FILL:   if (mem_ack) nstate = ST_RESP;
      ST_RESP:   nstate = ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
  end

  // Line arrays, request registers and memory-side registers. The line is
  // installed on the transition into RESP; the LRU touch happens in RESP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag       <= '0;
      data      <= '0;
      valid     <= '0;
      dirty     <= '0;
      r_wren    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_line    <= '0;
      resp_data <= '0;
      resp_hit  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r_wren <= req_wren;
            r_addr <= req_addr;
            r_data <= req_data;
          end
        end
        ST_LOOKUP: begin
          r_line   <= hit ? hit_line : victim;
          resp_hit <= hit;
          if (hit) begin
            resp_data <= r_wren ? r_data : data[hit_line];
            if (r_wren) begin
              data[hit_line]  <= r_data;
              dirty[hit_line] <= 1'b1;
            end
          end else if (victim_dirty) begin
            mem_addr  <= tag[victim];
            mem_wdata <= data[victim];
          end else if (r_wren) begin
            tag[victim]   <= r_addr;
            data[victim]  <= r_data;
            valid[victim] <= 1'b1;
            dirty[victim] <= 1'b1;
            resp_data     <= r_data;
          end else begin
            mem_addr <= r_addr;
          end
        end
        ST_EVICT: begin
          if (mem_ack) begin
            if (r_wren) begin
              tag[r_line]   <= r_addr;
              data[r_line]  <= r_data;
              valid[r_line] <= 1'b1;
              dirty[r_line] <= 1'b1;
              resp_data     <= r_data;
            end else begin
              mem_addr <= r_addr;
            end
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            tag[r_line]   <= r_addr;
            data[r_line]  <= mem_rdata;
            valid[r_line] <= 1'b1;
            dirty[r_line] <= 1'b0;
            resp_data     <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_cache_assoc.sv
module tb_m_cache_assoc;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wren = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_hit;
  logic       mem_req;
  logic       mem_wren;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;

  m_cache_assoc #(.LINES(4), .ADDR_W(8), .DATA_W(8)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wren(req_wren),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] data; logic hit; } resp_t;
  typedef struct { logic wren; logic [7:0] addr; logic [7:0] wdata; } mop_t;

  resp_t exp_q[$];
  mop_t  exp_mem_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int last_resp_cyc = 0;
  logic [7:0] last_data;
  logic       last_hit;
  int mem_req_cycles = 0;

  // Memory: acks a few cycles after mem_req rises, one phase at a time.
  logic [7:0] mem [256];
  int mcnt = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    mem_ack <= 1'b0;
    if (mem_req && !mem_ack) begin
      if (mcnt == 2) begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem[mem_addr];
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        mcnt <= 0;
      end else mcnt <= mcnt + 1;
    end else mcnt <= 0;
  end

  // Reference cache model
  logic [7:0] rtag [4];
  logic [7:0] rdat [4];
  logic       rval [4];
  logic       rdty [4];
  int         rage [4];
  logic [7:0] ref_mem [256];

  task automatic ref_reset();
    for (int i = 0; i < 4; i++) begin
      rval[i] = 0; rdty[i] = 0; rage[i] = i; rtag[i] = 0; rdat[i] = 0;
    end
    exp_q.delete();
    exp_mem_q.delete();
  endtask

  task automatic ref_access(input logic w, input logic [7:0] a, input logic [7:0] d);
    logic h; int k; logic found; resp_t r; mop_t m;
    h = 0; k = 0;
    for (int i = 0; i < 4; i++) if (rval[i] && rtag[i] == a) begin h = 1; k = i; end
    if (!h) begin
      found = 0;
      for (int i = 0; i < 4; i++) if (!found && !rval[i]) begin k = i; found = 1; end
      if (!found) for (int i = 0; i < 4; i++) if (rage[i] == 3) k = i;
      if (rval[k] && rdty[k]) begin
        m.wren = 1; m.addr = rtag[k]; m.wdata = rdat[k];
        exp_mem_q.push_back(m);
        ref_mem[rtag[k]] = rdat[k];
      end
      if (!w) begin
        m.wren = 0; m.addr = a; m.wdata = 0;
        exp_mem_q.push_back(m);
        rdat[k] = ref_mem[a]; rdty[k] = 0;
      end else begin
        rdat[k] = d; rdty[k] = 1;
      end
      rtag[k] = a; rval[k] = 1;
    end else if (w) begin
      rdat[k] = d; rdty[k] = 1;
    end
    for (int i = 0; i < 4; i++) if (rage[i] < rage[k]) rage[i]++;
    rage[k] = 0;
    r.data = rdat[k]; r.hit = h;
    exp_q.push_back(r);
  endtask

  // Response / memory-traffic monitor
  resp_t er;
  mop_t  em;
  logic [3:0] amask;
  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_req) mem_req_cycles++;
      if (resp_valid) begin
        last_resp_cyc = cyc; last_data = resp_data; last_hit = resp_hit;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected data=%h hit=%b", resp_data, resp_hit);
        end else begin
          er = exp_q.pop_front();
          if (resp_data !== er.data || resp_hit !== er.hit) begin
            failures++;
            $display("FAIL resp got data=%h hit=%b exp data=%h hit=%b",
                     resp_data, resp_hit, er.data, er.hit);
          end
        end
        amask = '0;
        for (int i = 0; i < 4; i++) amask[u_dut.ages[i]] = 1'b1;
        checks++;
        if (amask !== 4'hF) begin
          failures++;
          $display("FAIL age_perm got mask=%h exp=f", amask);
        end
      end
      if (mem_req && mem_ack) begin
        checks++;
        if (exp_mem_q.size() == 0) begin
          failures++;
          $display("FAIL mem_unexpected wren=%b addr=%h", mem_wren, mem_addr);
        end else begin
          em = exp_mem_q.pop_front();
          if (mem_wren !== em.wren || mem_addr !== em.addr ||
              (em.wren && mem_wdata !== em.wdata)) begin
            failures++;
            $display("FAIL mem_op got wren=%b addr=%h wdata=%h exp wren=%b addr=%h wdata=%h",
                     mem_wren, mem_addr, mem_wdata, em.wren, em.addr, em.wdata);
          end
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d);
    int n;
    ref_access(w, a, d);
    @(negedge clock);
    req_valid = 1; req_wren = w; req_addr = a; req_data = d;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clock); n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout got ready=0 exp ready=1");
    end
    accept_cyc = cyc;
    @(posedge clock); #1;
    req_valid = 0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clock); n++; end
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || exp_mem_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got pending resp=%0d mem=%0d exp 0", name,
               exp_q.size(), exp_mem_q.size());
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 0;
    req_valid = 0;
    ref_reset();
    repeat (2) @(negedge clock);
    reset_n = 1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 0;
    ref_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({req_ready, resp_valid, mem_req, mem_wren} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got %b exp 0000", {req_ready, resp_valid, mem_req, mem_wren});
    end
    checks++;
    if ({resp_data, mem_addr, mem_wdata} !== 24'h0) begin
      failures++;
      $display("FAIL reset_data got %h exp 000000", {resp_data, mem_addr, mem_wdata});
    end
    reset_n = 1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_read_miss_hit();
    int m0;
    do_req(0, 8'h05, 8'h00);
    wait_drain("read_miss");
    checks++;
    if (last_data !== 8'hA5 || last_hit !== 1'b0) begin
      failures++;
      $display("FAIL read_miss got data=%h hit=%b exp data=a5 hit=0", last_data, last_hit);
    end
    m0 = mem_req_cycles;
    do_req(0, 8'h05, 8'h00);
    wait_drain("read_hit");
    checks++;
    if (last_resp_cyc - accept_cyc != 2) begin
      failures++;
      $display("FAIL hit_latency got %0d exp 2", last_resp_cyc - accept_cyc);
    end
    checks++;
    if (mem_req_cycles != m0 || last_hit !== 1'b1) begin
      failures++;
      $display("FAIL read_hit got memcyc=%0d hit=%b exp memcyc=%0d hit=1",
               mem_req_cycles, last_hit, m0);
    end
  endtask

  task automatic test_write_alloc();
    int m0;
    m0 = mem_req_cycles;
    do_req(1, 8'h10, 8'h33);
    do_req(0, 8'h10, 8'h00);
    do_req(1, 8'h10, 8'h44);
    wait_drain("write_alloc");
    checks++;
    if (mem_req_cycles != m0) begin
      failures++;
      $display("FAIL write_no_mem got memcyc=%0d exp %0d", mem_req_cycles, m0);
    end
    checks++;
    if (last_hit !== 1'b1 || last_data !== 8'h44) begin
      failures++;
      $display("FAIL write_hit got data=%h hit=%b exp data=44 hit=1", last_data, last_hit);
    end
  endtask

  task automatic test_dirty_evict();
    apply_reset();
    for (int a = 1; a <= 4; a++) do_req(0, 8'(a), 8'h00);
    do_req(1, 8'h02, 8'h77);
    do_req(0, 8'h01, 8'h00);
    do_req(0, 8'h03, 8'h00);
    do_req(0, 8'h04, 8'h00);
    do_req(0, 8'h05, 8'h00);
    wait_drain("evict");
    checks++;
    if (mem[2] !== 8'h77) begin
      failures++;
      $display("FAIL evict_mem got mem[02]=%h exp 77", mem[2]);
    end
    do_req(0, 8'h02, 8'h00);
    wait_drain("evict_reread");
    checks++;
    if (last_hit !== 1'b0 || last_data !== 8'h77) begin
      failures++;
      $display("FAIL evict_reread got data=%h hit=%b exp data=77 hit=0", last_data, last_hit);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    do_req(0, 8'h40, 8'h00);
    do_req(0, 8'h41, 8'h00);
    checks++;
    if (accept_cyc != last_resp_cyc + 1) begin
      failures++;
      $display("FAIL b2b_accept got cyc=%0d exp %0d", accept_cyc, last_resp_cyc + 1);
    end
    r0 = last_resp_cyc;
    wait_drain("b2b");
    checks++;
    if (last_resp_cyc <= r0 || last_data !== 8'hE1) begin
      failures++;
      $display("FAIL b2b_order got data=%h exp e1", last_data);
    end
  endtask

  task automatic test_reset_mid_fill();
    int n;
    apply_reset();
    do_req(0, 8'h05, 8'h00);
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clock); n++; end
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b1 || mem_wren !== 1'b0) begin
      failures++;
      $display("FAIL fill_phase got req=%b wren=%b exp req=1 wren=0", mem_req, mem_wren);
    end
    reset_n = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort got req=%b resp=%b exp 0 0", mem_req, resp_valid);
    end
    ref_reset();
    repeat (2) @(negedge clock);
    reset_n = 1;
    repeat (6) @(negedge clock);
    do_req(0, 8'h05, 8'h00);
    wait_drain("after_abort");
    checks++;
    if (last_hit !== 1'b0 || last_data !== 8'hA5) begin
      failures++;
      $display("FAIL after_abort got data=%h hit=%b exp data=a5 hit=0", last_data, last_hit);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 2000; i++)
      do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 11)), 8'($urandom));
    wait_drain("random");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'hA0;
      ref_mem[i] = 8'(i) ^ 8'hA0;
    end
    test_reset();
    test_read_miss_hit();
    test_write_alloc();
    test_dirty_evict();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
